// File: rtl/hid_shift_rx.sv
// hid_shift_rx: receives framed serial words on an asynchronous three-wire
// interface (shift clock, data, strobe) and queues complete frames in a small
// FIFO with a registered head word. Frame length errors and drops caused by a
// full FIFO are reported on sticky flags that clear_err resets.
module hid_shift_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            hid_clk,
    input  logic                            hid_dat,
    input  logic                            hid_str,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            frame_err,
    input  logic                            clear_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 2);

    // Bit positions inside the packed synchronizer vectors.
    localparam int SIG_CLK = 0;
    localparam int SIG_DAT = 1;
    localparam int SIG_STR = 2;

    logic [2:0]              pins;
    logic [2:0]              sync1_reg;
    logic [2:0]              sync2_reg;
    logic [2:0]              hist_reg;
    logic [2:0]              rise;

    logic [DATA_W-1:0]       shreg_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;

    logic [DATA_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_inc;
    logic [PTR_W:0]          count_reg;
    logic [PTR_W:0]          count_next;
    logic [DATA_W-1:0]       rd_data_reg;
    logic [DATA_W-1:0]       rd_data_next;
    logic                    overflow_reg;
    logic                    frame_err_reg;

    logic                    clk_rise;
    logic                    str_rise;
    logic                    frame_ok;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    bad_frame;

    assign pins = {hid_str, hid_dat, hid_clk};

    // Two-stage synchronizer plus one history stage per input pin.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            hist_reg  <= '0;
        end else begin
            sync1_reg <= pins;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    // Rising edge: synced value high while the history value is still low.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rise
            assign rise[gi] = sync2_reg[gi] & ~hist_reg[gi];
        end
    endgenerate

    assign clk_rise   = rise[SIG_CLK];
    assign str_rise   = rise[SIG_STR];
    assign frame_ok   = (bit_cnt_reg == CNT_W'(DATA_W));
    assign full       = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = rd_valid && rd_ready;
    assign push       = str_rise && frame_ok && (!full || pop);
    assign drop       = str_rise && frame_ok && full && !pop;
    assign bad_frame  = str_rise && !frame_ok;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    // Shift register and bit counter; a strobe in the same cycle as a shift
    // edge wins, so the shift is discarded and the count restarts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (str_rise) begin
            bit_cnt_reg <= '0;
        end else if (clk_rise) begin
            shreg_reg <= {shreg_reg[DATA_W-2:0], sync2_reg[SIG_DAT]};
            if (bit_cnt_reg != CNT_W'(DATA_W + 1)) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // FIFO storage write port; contents need no reset because occupancy
    // tracking decides what is visible.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= shreg_reg;
        end
    end

    // Next occupancy and next head word. The head is kept in a register so
    // rd_data is valid exactly when rd_valid is high.
    always_comb begin
        count_next   = count_reg;
        rd_data_next = rd_data_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
        if (pop) begin
            if (count_reg == (PTR_W+1)'(1)) begin
                if (push) begin
                    rd_data_next = shreg_reg;
                end
            end else begin
                rd_data_next = mem[rd_ptr_inc];
            end
        end else if (count_reg == '0 && push) begin
            rd_data_next = shreg_reg;
        end
    end

    // FIFO pointers, occupancy and registered head word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg   <= count_next;
            rd_data_reg <= rd_data_next;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_err) begin
                overflow_reg <= 1'b0;
            end
            if (bad_frame) begin
                frame_err_reg <= 1'b1;
            end else if (clear_err) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = (count_reg != '0);
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_hid_shift_rx.sv
// Testbench for hid_shift_rx: directed frames with a scoreboard queue of
// expected words; a monitor compares every word the DUT hands out.
module tb_hid_shift_rx;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 hid_clk = 1'b0;
    logic                 hid_dat = 1'b0;
    logic                 hid_str = 1'b0;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 rd_ready = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                 overflow;
    logic                 frame_err;
    logic                 clear_err = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    hid_shift_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .hid_clk    (hid_clk),
        .hid_dat    (hid_dat),
        .hid_str    (hid_str),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clear_err  (clear_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    // Monitor: every accepted head word must match the scoreboard front.
    always @(negedge sys_clk) begin
        if (sys_rst_n && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop: got 0x%0h expected nothing queued", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop: got 0x%0h expected 0x%0h", rd_data, e);
                end else begin
                    $display("ok   pop: 0x%0h", rd_data);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        cycles(1);
        hid_dat = b;
        cycles(2);
        hid_clk = 1'b1;
        cycles(4);
        hid_clk = 1'b0;
        cycles(4);
    endtask

    // Strobe; optionally pop and/or pulse clear_err in the exact cycle the
    // strobe edge is acted on (third rising edge after the pin change).
    task automatic strobe(input logic pop_at, input logic clr_at);
        cycles(1);
        hid_str = 1'b1;
        cycles(2);
        rd_ready  = pop_at;
        clear_err = clr_at;
        cycles(1);
        rd_ready  = 1'b0;
        clear_err = 1'b0;
        cycles(2);
        hid_str = 1'b0;
        cycles(5);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] v, input logic expect_push);
        send_bits(16'(v), DATA_W);
        if (expect_push) exp_q.push_back(v);
        strobe(1'b0, 1'b0);
    endtask

    task automatic pop_one();
        cycles(1);
        rd_ready = 1'b1;
        cycles(1);
        rd_ready = 1'b0;
        cycles(1);
    endtask

    task automatic pulse_clear();
        cycles(1);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycles(3);
        check("reset rd_valid", int'(rd_valid), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset count", int'(fifo_count), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset frame_err", int'(frame_err), 0);
        sys_rst_n = 1'b1;
        cycles(3);

        // Single frame 0xA5 (bits 1,0,1,0,0,1,0,1).
        send_frame(8'hA5, 1'b1);
        check("a5 rd_valid", int'(rd_valid), 1);
        check("a5 rd_data", int'(rd_data), 'hA5);
        check("a5 count", int'(fifo_count), 1);
        pop_one();
        check("a5 after pop rd_valid", int'(rd_valid), 0);

        // Five frames into a four-entry FIFO.
        for (int k = 1; k <= 5; k++) send_frame(8'(k), k <= 4);
        check("fill count", int'(fifo_count), 4);
        check("fill overflow", int'(overflow), 1);
        check("fill frame_err", int'(frame_err), 0);
        for (int k = 0; k < 4; k++) pop_one();
        check("drain count", int'(fifo_count), 0);
        pulse_clear();
        check("clear overflow", int'(overflow), 0);

        // Short and long frames are rejected, then a good frame passes.
        send_bits(16'h55, 7);
        strobe(1'b0, 1'b0);
        check("short frame_err", int'(frame_err), 1);
        check("short count", int'(fifo_count), 0);
        pulse_clear();
        check("short cleared", int'(frame_err), 0);
        send_bits(16'h1FF, 9);
        strobe(1'b0, 1'b0);
        check("long frame_err", int'(frame_err), 1);
        check("long count", int'(fifo_count), 0);
        send_frame(8'h3C, 1'b1);
        check("3c count", int'(fifo_count), 1);
        check("3c rd_data", int'(rd_data), 'h3C);
        pop_one();
        pulse_clear();

        // Fill and overflow, then clear_err coinciding with a short strobe.
        for (int k = 0; k < 5; k++) send_frame(8'h10 + 8'(k), k < 4);
        check("refill overflow", int'(overflow), 1);
        send_bits(16'h5, 3);
        strobe(1'b0, 1'b1);
        check("set wins frame_err", int'(frame_err), 1);
        check("set wins overflow cleared", int'(overflow), 0);
        pulse_clear();
        check("clear alone frame_err", int'(frame_err), 0);
        check("clear alone overflow", int'(overflow), 0);
        check("still full count", int'(fifo_count), 4);

        // Full FIFO: push of 0x77 coincides with a pop.
        send_bits(16'h77, 8);
        exp_q.push_back(8'h77);
        strobe(1'b1, 1'b0);
        check("push+pop count", int'(fifo_count), 4);
        check("push+pop overflow", int'(overflow), 0);
        for (int k = 0; k < 4; k++) pop_one();
        check("drain2 count", int'(fifo_count), 0);

        // Reset in the middle of a frame, then a clean frame 0x81.
        send_bits(16'hF, 4);
        cycles(1);
        sys_rst_n = 1'b0;
        cycles(3);
        sys_rst_n = 1'b1;
        cycles(3);
        send_frame(8'h81, 1'b1);
        check("post-reset rd_data", int'(rd_data), 'h81);
        check("post-reset count", int'(fifo_count), 1);
        check("post-reset frame_err", int'(frame_err), 0);
        pop_one();

        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
